// File: rtl/wb_write_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter.
// WB_R0_DISCARD_EN (when defined) drops every result that targets register 0.
package wb_write_arbiter_pkg;

  localparam int unsigned WB_REG_W  = 4;
  localparam int unsigned WB_DATA_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [WB_REG_W-1:0]  dst;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MEM,
    SEL_FIFO,
    SEL_ALU
  } wb_sel_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer of ALU results that lost write-port arbitration, with
// per-entry squash by destination and a match-any pending query.
module wb_result_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [REG_W-1:0]  push_dst_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              squash_i,
  input  logic [REG_W-1:0]  squash_dst_i,
  input  logic [REG_W-1:0]  qry_reg_i,
  output logic              qry_pending_o,
  output logic              head_valid_o,
  output logic [REG_W-1:0]  head_dst_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [REG_W-1:0]  dst_q  [DEPTH];
  logic [REG_W-1:0]  dst_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    valid_d = valid_q;
    dst_d   = dst_q;
    data_d  = data_q;
    // Squash hits only entries already stored; a same-cycle push is younger.
    for (int i = 0; i < DEPTH; i++) begin
      if (squash_i && (dst_q[i] == squash_dst_i)) begin
        valid_d[i] = 1'b0;
      end
    end
    if (pop_i) begin
      valid_d[rd_q] = 1'b0;
    end
    if (push_i) begin
      valid_d[wr_q] = 1'b1;
      dst_d[wr_q]   = push_dst_i;
      data_d[wr_q]  = push_data_i;
    end
    rd_d    = pop_i  ? rd_q + PTR_W'(1) : rd_q;
    wr_d    = push_i ? wr_q + PTR_W'(1) : wr_q;
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_comb begin
    qry_pending_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (dst_q[i] == qry_reg_i) &&
          !(squash_i && (dst_q[i] == squash_dst_i))) begin
        qry_pending_o = 1'b1;
      end
    end
  end

  assign head_valid_o = valid_q[rd_q];
  assign head_dst_o   = dst_q[rd_q];
  assign head_data_o  = data_q[rd_q];
  assign count_o      = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: mem results first, then buffered ALU results,
// then direct ALU results. Optional macro WB_R0_DISCARD_EN drops writes to register 0.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned REG_W  = WB_REG_W,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_W-1:0]  alu_dst,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [REG_W-1:0]  mem_dst,
  input  logic [DATA_W-1:0] mem_data,
  output logic              WriteReg,
  output logic [REG_W-1:0]  DstReg,
  output logic [DATA_W-1:0] DstData,
  input  logic [REG_W-1:0]  qry_reg,
  output logic              qry_pending,
  output logic [CNT_W-1:0]  fifo_count
);

  logic              write_q, write_d;
  logic [REG_W-1:0]  dst_q, dst_d;
  logic [DATA_W-1:0] data_q, data_d;

  wb_sel_e           sel;
  logic              mem_eff, alu_acc, alu_keep, push, pop;
  logic              head_valid, fifo_qry;
  logic [REG_W-1:0]  head_dst;
  logic [DATA_W-1:0] head_data;

`ifdef WB_R0_DISCARD_EN
  assign mem_eff     = mem_valid && (mem_dst != '0);
  assign alu_keep    = alu_dst != '0;
  assign qry_pending = fifo_qry && (qry_reg != '0);
`else
  assign mem_eff     = mem_valid;
  assign alu_keep    = 1'b1;
  assign qry_pending = fifo_qry;
`endif

  assign alu_ready = (fifo_count < CNT_W'(DEPTH)) || !mem_valid;
  assign alu_acc   = alu_valid && alu_ready;

  always_comb begin
    sel = SEL_NONE;
    if (mem_eff) begin
      sel = SEL_MEM;
    end else if (fifo_count != '0) begin
      sel = SEL_FIFO;
    end else if (alu_acc && alu_keep) begin
      sel = SEL_ALU;
    end
  end

  // ALU results queue behind any write that takes the port ahead of them.
  assign push = alu_acc && alu_keep && ((sel == SEL_MEM) || (sel == SEL_FIFO));
  assign pop  = (sel == SEL_FIFO);

  always_comb begin
    write_d = 1'b0;
    dst_d   = dst_q;
    data_d  = data_q;
    unique case (sel)
      SEL_MEM: begin
        write_d = 1'b1;
        dst_d   = mem_dst;
        data_d  = mem_data;
      end
      SEL_FIFO: begin
        if (head_valid) begin
          write_d = 1'b1;
          dst_d   = head_dst;
          data_d  = head_data;
        end
      end
      SEL_ALU: begin
        write_d = 1'b1;
        dst_d   = alu_dst;
        data_d  = alu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      dst_q   <= '0;
      data_q  <= '0;
    end else begin
      write_q <= write_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
    end
  end

  assign WriteReg = write_q;
  assign DstReg   = dst_q;
  assign DstData  = data_q;

  wb_result_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push),
    .push_dst_i    (alu_dst),
    .push_data_i   (alu_data),
    .pop_i         (pop),
    .squash_i      (mem_eff),
    .squash_dst_i  (mem_dst),
    .qry_reg_i     (qry_reg),
    .qry_pending_o (fifo_qry),
    .head_valid_o  (head_valid),
    .head_dst_o    (head_dst),
    .head_data_o   (head_data),
    .count_o       (fifo_count)
  );

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed vector bench for wb_write_arbiter (DEPTH=4, DATA_W=16, REG_W=4).
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid;
  logic [3:0]  alu_dst, mem_dst, qry_reg, DstReg;
  logic [15:0] alu_data, mem_data, DstData;
  logic        WriteReg, qry_pending;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(
    .DEPTH  (4),
    .DATA_W (16),
    .REG_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_dst     (alu_dst),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_dst     (mem_dst),
    .mem_data    (mem_data),
    .WriteReg    (WriteReg),
    .DstReg      (DstReg),
    .DstData     (DstData),
    .qry_reg     (qry_reg),
    .qry_pending (qry_pending),
    .fifo_count  (fifo_count)
  );

  typedef struct {
    logic        av;
    logic [3:0]  ad;
    logic [15:0] adat;
    logic        mv;
    logic [3:0]  md;
    logic [15:0] mdat;
    logic [3:0]  q;
    logic        rdy;
    logic        qp;
    logic        wr;
    logic [3:0]  dst;
    logic [15:0] dat;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [3:0] ad, logic [15:0] adat,
                              logic mv, logic [3:0] md, logic [15:0] mdat,
                              logic [3:0] q, logic rdy, logic qp, logic wr,
                              logic [3:0] dst, logic [15:0] dat, logic [2:0] cnt);
    vec_t v;
    v.av = av; v.ad = ad; v.adat = adat;
    v.mv = mv; v.md = md; v.mdat = mdat; v.q = q;
    v.rdy = rdy; v.qp = qp; v.wr = wr; v.dst = dst; v.dat = dat; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ad, input logic [15:0] adat,
                       input logic mv, input logic [3:0] md, input logic [15:0] mdat,
                       input logic [3:0] q);
    alu_valid = av; alu_dst = ad; alu_data = adat;
    mem_valid = mv; mem_dst = md; mem_data = mdat; qry_reg = q;
  endtask

  initial begin
    // av ad adat     mv md mdat     q   rdy qp wr dst dat      cnt
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  1, 0, 0, 0,  16'h0000, 0));
    vecs.push_back(mk(1, 3, 16'h1234, 0, 0, 16'h0000, 3,  1, 0, 1, 3,  16'h1234, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 3,  1, 0, 0, 3,  16'h1234, 0));
    vecs.push_back(mk(1, 6, 16'h0001, 1, 5, 16'hAAAA, 6,  1, 0, 1, 5,  16'hAAAA, 1));
    vecs.push_back(mk(1, 7, 16'h0002, 0, 0, 16'h0000, 6,  1, 1, 1, 6,  16'h0001, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 7,  1, 1, 1, 7,  16'h0002, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 7,  1, 0, 0, 7,  16'h0002, 0));
    vecs.push_back(mk(1, 4, 16'h1111, 1, 1, 16'h00AA, 4,  1, 0, 1, 1,  16'h00AA, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 9, 16'h0999, 4,  1, 1, 1, 9,  16'h0999, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 4, 16'h2222, 4,  1, 0, 1, 4,  16'h2222, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 4,  1, 0, 0, 4,  16'h2222, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 4,  1, 0, 0, 4,  16'h2222, 0));
    vecs.push_back(mk(1, 10, 16'h000A, 1, 8, 16'h0800, 10, 1, 0, 1, 8, 16'h0800, 1));
    vecs.push_back(mk(1, 11, 16'h000B, 1, 8, 16'h0801, 10, 1, 1, 1, 8, 16'h0801, 2));
    vecs.push_back(mk(1, 12, 16'h000C, 1, 8, 16'h0802, 11, 1, 1, 1, 8, 16'h0802, 3));
    vecs.push_back(mk(1, 13, 16'h000D, 1, 8, 16'h0803, 12, 1, 1, 1, 8, 16'h0803, 4));
    vecs.push_back(mk(1, 14, 16'h000E, 1, 8, 16'h0804, 13, 0, 1, 1, 8, 16'h0804, 4));
    vecs.push_back(mk(1, 14, 16'h000E, 0, 0, 16'h0000, 10, 1, 1, 1, 10, 16'h000A, 4));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 10, 1, 0, 1, 11, 16'h000B, 3));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 14, 1, 1, 1, 12, 16'h000C, 2));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 14, 1, 1, 1, 13, 16'h000D, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 14, 1, 1, 1, 14, 16'h000E, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 14, 1, 0, 0, 14, 16'h000E, 0));
    vecs.push_back(mk(1, 2, 16'h0022, 1, 1, 16'h0101, 2,  1, 0, 1, 1,  16'h0101, 1));
`ifdef WB_R0_DISCARD_EN
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0F0F, 0,  1, 0, 1, 2,  16'h0022, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  1, 0, 0, 2,  16'h0022, 0));
`else
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0F0F, 0,  1, 0, 1, 0,  16'h0F0F, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  1, 0, 1, 2,  16'h0022, 0));
`endif

    rst = 1'b1;
    drive(0, 0, 16'h0, 0, 0, 16'h0, 0);
    #1;
    check("reset_wr",  {31'd0, WriteReg}, 32'd0);
    check("reset_dst", {28'd0, DstReg}, 32'd0);
    check("reset_dat", {16'd0, DstData}, 32'd0);
    check("reset_cnt", {29'd0, fifo_count}, 32'd0);
    check("reset_qp",  {31'd0, qry_pending}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].ad, vecs[i].adat, vecs[i].mv, vecs[i].md, vecs[i].mdat,
            vecs[i].q);
      #1;
      check($sformatf("v%0d_rdy", i), {31'd0, alu_ready}, {31'd0, vecs[i].rdy});
      check($sformatf("v%0d_qp", i), {31'd0, qry_pending}, {31'd0, vecs[i].qp});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wr", i), {31'd0, WriteReg}, {31'd0, vecs[i].wr});
      check($sformatf("v%0d_dst", i), {28'd0, DstReg}, {28'd0, vecs[i].dst});
      check($sformatf("v%0d_dat", i), {16'd0, DstData}, {16'd0, vecs[i].dat});
      check($sformatf("v%0d_cnt", i), {29'd0, fifo_count}, {29'd0, vecs[i].cnt});
    end

    // Reset mid-stream with two buffered entries.
    @(negedge clk);
    drive(1, 2, 16'h0222, 1, 1, 16'h0111, 2);
    @(negedge clk);
    drive(1, 3, 16'h0333, 1, 1, 16'h0112, 2);
    @(posedge clk);
    #1;
    check("mid_cnt_pre", {29'd0, fifo_count}, 32'd2);
    check("mid_wr_pre", {31'd0, WriteReg}, 32'd1);
    @(negedge clk);
    drive(0, 0, 16'h0, 0, 0, 16'h0, 2);
    #1;
    check("mid_qp_pre", {31'd0, qry_pending}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_wr_rst", {31'd0, WriteReg}, 32'd0);
    check("mid_cnt_rst", {29'd0, fifo_count}, 32'd0);
    check("mid_qp_rst", {31'd0, qry_pending}, 32'd0);
    check("mid_dst_rst", {28'd0, DstReg}, 32'd0);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d_wr", c), {31'd0, WriteReg}, 32'd0);
      check($sformatf("post_rst%0d_cnt", c), {29'd0, fifo_count}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer-side master for the register file's single write port (DstReg/WriteReg/DstData).
- Merges ALU results and load (memory) results into one write per cycle and buffers ALU results that lose arbitration.
- Preserves write-after-write order and reports whether a buffered write targets a given source register, so decode can stall.
- Sits between the execute/memory stages and the register file.

Parameters:
DEPTH, 4, number of ALU-result buffer entries (power of two, >=2)
DATA_W, 16, data width
REG_W, 4, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle when alu_valid & alu_ready
alu_dst  in  REG_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load result present; always accepted, never stalled
mem_dst  in  REG_W  load destination register
mem_data  in  DATA_W  load data
WriteReg  out  1  register-file write enable (registered)
DstReg  out  REG_W  register-file write index (registered)
DstData  out  DATA_W  register-file write data (registered)
qry_reg  in  REG_W  register to check for a pending write
qry_pending  out  1  combinational: a valid buffer entry targets qry_reg
fifo_count  out  $clog2(DEPTH+1)  occupied entries, valid or squashed

Behaviour:
- Reset: asynchronous and active-high. WriteReg=0, DstReg=0, DstData=0, FIFO empty (count=0, all entry valid bits 0). qry_pending and fifo_count are therefore 0.
- Reset mid-operation discards all buffered writes. No write is issued on the release cycle.
- Latency: the result selected in cycle t appears on WriteReg/DstReg/DstData in cycle t+1, held for exactly one cycle.
- Ordering guarantee from the pipeline: a mem result is younger than every buffered ALU entry and older than a same-cycle ALU result.
- Per-cycle selection, in priority order:
  1. mem_valid: write mem result. Clear the valid bit of every FIFO entry whose dst == mem_dst (squash, WAW). An accepted ALU result is enqueued.
  2. Else FIFO non-empty: pop the head. If the head is valid, write it. If squashed, WriteReg=0 next cycle (slot consumed, no write). An accepted ALU result is enqueued in the same cycle.
  3. Else alu_valid: write the ALU result directly; nothing is enqueued.
  4. Else WriteReg=0 next cycle; DstReg/DstData hold their previous value.
- An ALU result never bypasses non-empty FIFO contents; ALU results are written in arrival order.
- alu_ready = (fifo_count < DEPTH) | ~mem_valid.
  - When full and mem idle, pop and push happen in the same cycle; count is unchanged.
  - When full and mem_valid=1, alu_ready=0 and the producer holds its result.
- An entry enqueued in the same cycle as a mem squash is not squashed; it is younger.
- Pointers wrap modulo DEPTH.
- Count update: count + push − pop, where squashed pops count as pops.
- qry_pending ignores squashed entries and the already-registered output. The register file's same-cycle bypass covers the registered output.

Optional Feature:
- WB_R0_DISCARD_EN defined: results with dst == 0 (ALU or mem) are dropped.
  - Dropped ALU result: accepted (alu_ready rules unchanged), never enqueued, never written.
  - Dropped mem result: does not win arbitration, so the FIFO head or an ALU result may write that cycle, and it squashes nothing.
  - qry_reg=0 always reports 0.
- WB_R0_DISCARD_EN undefined: register 0 is handled like any other register.

Decomposition:
- Shared package:
  - REG_W and DATA_W defaults.
  - wb_entry_t struct {valid, dst[REG_W], data[DATA_W]}.
  - Write-source select enum {SEL_NONE, SEL_MEM, SEL_FIFO, SEL_ALU}.
- One natural sub-module: wb_result_fifo.
  - Circular buffer with per-entry squash-by-dst and a match-any query port.
  - The arbiter top holds selection logic and output registers.

Test Plan:
- Reset mid-stream: FIFO holds 2 entries, rst pulsed asynchronously between edges → WriteReg=0 and fifo_count=0 immediately, no write afterwards.
- ALU only: alu R3=0x1234 at t → WriteReg=1, DstReg=3, DstData=0x1234 at t+1; FIFO stays empty.
- Collision: mem R5=0xAAAA and alu R6=0x0001 at t → t+1 writes R5. alu R7=0x0002 at t+1 is enqueued behind R6. t+2 writes R6, t+3 writes R7.
- Squash: FIFO holds R4=0x1111, then mem R4=0x2222 → t+1 writes R4=0x2222. The following pop produces a WriteReg=0 cycle and R4 is never overwritten with 0x1111. qry_reg=4 drops to 0 in the squash cycle.
- Backpressure: DEPTH=4 full with mem_valid=1 → alu_ready=0. Next cycle mem idle → alu_ready=1, push and pop together, fifo_count stays 4.
- WB_R0_DISCARD_EN: mem R0 with FIFO head R2 → t+1 writes R2. Without the macro → t+1 writes R0.
